// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [1:0] WSIZE_NONE = 2'b00;
    localparam logic [1:0] WSIZE_BYTE = 2'b01;
    localparam logic [1:0] WSIZE_HALF = 2'b10;
    localparam logic [1:0] WSIZE_WORD = 2'b11;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and memory signal bundle of the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  i_cpu_req;
    logic                  i_cpu_we;
    logic [ADDR_WIDTH-1:0] i_cpu_addr;
    logic [31:0]           i_cpu_wdata;
    logic [1:0]            i_cpu_wsize;
    logic                  o_cpu_gnt;
    logic                  o_cpu_rvalid;
    logic [31:0]           o_cpu_rdata;

    logic                  i_dbg_req;
    logic                  i_dbg_we;
    logic [ADDR_WIDTH-1:0] i_dbg_addr;
    logic [31:0]           i_dbg_wdata;
    logic [1:0]            i_dbg_wsize;
    logic                  i_dbg_lock;
    logic                  o_dbg_gnt;
    logic                  o_dbg_rvalid;
    logic [31:0]           o_dbg_rdata;

    logic [31:0]           o_mem_din;
    logic [ADDR_WIDTH-1:0] o_mem_waddr;
    logic [ADDR_WIDTH-1:0] o_mem_raddr;
    logic [1:0]            o_mem_wsize;
    logic                  o_mem_wen;
    logic                  o_mem_ren;
    logic [31:0]           i_mem_dout;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wsize,
        output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_wsize, i_dbg_lock,
        output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
        output o_mem_din, o_mem_waddr, o_mem_raddr, o_mem_wsize, o_mem_wen, o_mem_ren,
        input  i_mem_dout
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_wsize,
        input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_wsize, i_dbg_lock,
        input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
        input  o_mem_din, o_mem_waddr, o_mem_raddr, o_mem_wsize, o_mem_wen, o_mem_ren,
        output i_mem_dout
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-input round-robin grant with last-owner register
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic i_rst,
    input  logic i_req_cpu,
    input  logic i_req_dbg,
    input  logic i_dbg_only,
    output logic o_gnt_cpu,
    output logic o_gnt_dbg
);

    owner_e last_q;
    owner_e last_d;

    // On contention the requester that did not own the previous grant wins.
    always_comb begin
        o_gnt_cpu = 1'b0;
        o_gnt_dbg = 1'b0;
        if (!i_rst) begin
            if (i_dbg_only) begin
                o_gnt_dbg = i_req_dbg;
            end else if (i_req_cpu && i_req_dbg) begin
                o_gnt_cpu = (last_q == OWN_DBG);
                o_gnt_dbg = (last_q == OWN_CPU);
            end else begin
                o_gnt_cpu = i_req_cpu;
                o_gnt_dbg = i_req_dbg;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (o_gnt_cpu) begin
            last_d = OWN_CPU;
        end else if (o_gnt_dbg) begin
            last_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            last_q <= OWN_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug data-memory arbiter with debug lock and read-response routing
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           i_rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       cpu_rvalid_q;
    logic       cpu_rvalid_d;
    logic       dbg_rvalid_q;
    logic       dbg_rvalid_d;
    logic       cpu_gnt;
    logic       dbg_gnt;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_req_cpu  (bus.i_cpu_req),
        .i_req_dbg  (bus.i_dbg_req),
        .i_dbg_only (state_q == ST_LOCK),
        .o_gnt_cpu  (cpu_gnt),
        .o_gnt_dbg  (dbg_gnt)
    );

    // While locked every debug grant keeps last-owner at debug, so the CPU wins first after release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (dbg_gnt && bus.i_dbg_lock) state_d = ST_LOCK;
            ST_LOCK: if (!bus.i_dbg_lock)           state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        cpu_rvalid_d = cpu_gnt & ~bus.i_cpu_we;
        dbg_rvalid_d = dbg_gnt & ~bus.i_dbg_we;
    end

    always_comb begin
        bus.o_mem_waddr = ADDR_ZERO;
        bus.o_mem_din   = 32'h0;
        bus.o_mem_wsize = WSIZE_NONE;
        bus.o_mem_wen   = 1'b0;
        bus.o_mem_ren   = 1'b0;
        if (cpu_gnt) begin
            bus.o_mem_waddr = bus.i_cpu_addr;
            bus.o_mem_din   = bus.i_cpu_wdata;
            bus.o_mem_wsize = bus.i_cpu_wsize;
            bus.o_mem_wen   = bus.i_cpu_we;
            bus.o_mem_ren   = ~bus.i_cpu_we;
        end else if (dbg_gnt) begin
            bus.o_mem_waddr = bus.i_dbg_addr;
            bus.o_mem_din   = bus.i_dbg_wdata;
            bus.o_mem_wsize = bus.i_dbg_wsize;
            bus.o_mem_wen   = bus.i_dbg_we;
            bus.o_mem_ren   = ~bus.i_dbg_we;
        end
    end

    assign bus.o_mem_raddr  = bus.o_mem_waddr;
    assign bus.o_cpu_gnt    = cpu_gnt;
    assign bus.o_dbg_gnt    = dbg_gnt;

    // Masking with i_rst drops a response whose read was granted the cycle before reset.
    assign bus.o_cpu_rvalid = cpu_rvalid_q & ~i_rst;
    assign bus.o_dbg_rvalid = dbg_rvalid_q & ~i_rst;
    assign bus.o_cpu_rdata  = bus.o_cpu_rvalid ? bus.i_mem_dout : 32'h0;
    assign bus.o_dbg_rdata  = bus.o_dbg_rvalid ? bus.i_mem_dout : 32'h0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= ST_ARB;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector table plus random scoreboard traffic for dmem_arbiter
module tb_dmem_arbiter;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  wsize;
    } port_t;

    typedef struct packed {
        logic        gc;
        logic        gd;
        logic        rvc;
        logic [31:0] rdc;
        logic        rvd;
        logic [31:0] rdd;
        logic        wen;
        logic        ren;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [1:0]  wsz;
    } exp_t;

    typedef struct {
        logic  rst;
        logic  lk;
        port_t c;
        port_t d;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(5)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [7:0] mem [32] = '{default: 8'h00};
    logic [7:0] sb  [32] = '{default: 8'h00};
    logic [4:0] ma;

    always @(posedge clk) begin
        ma = bus.o_mem_waddr;
        if (bus.o_mem_wen) begin
            if (bus.o_mem_wsize != 2'b00) mem[ma] <= bus.o_mem_din[7:0];
            if (bus.o_mem_wsize[1]) mem[ma + 5'd1] <= bus.o_mem_din[15:8];
            if (bus.o_mem_wsize == 2'b11) begin
                mem[ma + 5'd2] <= bus.o_mem_din[23:16];
                mem[ma + 5'd3] <= bus.o_mem_din[31:24];
            end
        end
        if (bus.o_mem_ren) begin
            bus.i_mem_dout <= {mem[bus.o_mem_raddr + 5'd3], mem[bus.o_mem_raddr + 5'd2],
                               mem[bus.o_mem_raddr + 5'd1], mem[bus.o_mem_raddr]};
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    vec_t tv[$];
    localparam port_t IDLE = '0;
    localparam exp_t  NONE = '0;

    function automatic port_t rd(input logic [4:0] a);
        port_t p = '0;
        p.req  = 1'b1;
        p.addr = a;
        return p;
    endfunction

    function automatic port_t wr(input logic [4:0] a, input logic [31:0] d, input logic [1:0] s);
        port_t p = '0;
        p.req = 1'b1; p.we = 1'b1; p.addr = a; p.wdata = d; p.wsize = s;
        return p;
    endfunction

    function automatic exp_t acc(input logic gc, input logic gd, input port_t p);
        exp_t e = '0;
        e.gc = gc; e.gd = gd; e.wen = p.we; e.ren = ~p.we;
        e.addr = p.addr; e.din = p.wdata; e.wsz = p.wsize;
        return e;
    endfunction

    function automatic exp_t rvc(input exp_t e, input logic [31:0] d);
        exp_t r = e;
        r.rvc = 1'b1; r.rdc = d;
        return r;
    endfunction

    function automatic exp_t rvd(input exp_t e, input logic [31:0] d);
        exp_t r = e;
        r.rvd = 1'b1; r.rdd = d;
        return r;
    endfunction

    task automatic add(input logic rst, input logic lk, input port_t c, input port_t d, input exp_t e);
        vec_t v;
        v.rst = rst; v.lk = lk; v.c = c; v.d = d; v.e = e;
        tv.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic lk, input port_t c, input port_t d);
        i_rst           = rst;
        bus.i_dbg_lock  = lk;
        bus.i_cpu_req   = c.req;  bus.i_cpu_we = c.we;  bus.i_cpu_addr = c.addr;
        bus.i_cpu_wdata = c.wdata; bus.i_cpu_wsize = c.wsize;
        bus.i_dbg_req   = d.req;  bus.i_dbg_we = d.we;  bus.i_dbg_addr = d.addr;
        bus.i_dbg_wdata = d.wdata; bus.i_dbg_wsize = d.wsize;
    endtask

    function automatic logic [31:0] sb_word(input logic [4:0] a);
        return {sb[a + 5'd3], sb[a + 5'd2], sb[a + 5'd1], sb[a]};
    endfunction

    task automatic sb_write(input port_t p);
        if (p.wsize != 2'b00) sb[p.addr] = p.wdata[7:0];
        if (p.wsize[1]) sb[p.addr + 5'd1] = p.wdata[15:8];
        if (p.wsize == 2'b11) begin
            sb[p.addr + 5'd2] = p.wdata[23:16];
            sb[p.addr + 5'd3] = p.wdata[31:24];
        end
    endtask

    exp_t  got;
    port_t rc, rdp;
    logic  exp_c, exp_d;
    logic [31:0] exp_cd, exp_dd;

    initial begin
        drive(1'b1, 1'b0, IDLE, IDLE);

        add(1, 0, rd(5'h04), rd(5'h08), NONE);
        add(0, 0, wr(5'h04, 32'h11223344, 2'b11), IDLE, acc(1, 0, wr(5'h04, 32'h11223344, 2'b11)));
        add(0, 0, IDLE, wr(5'h08, 32'h55667788, 2'b11), acc(0, 1, wr(5'h08, 32'h55667788, 2'b11)));
        add(0, 0, rd(5'h04), rd(5'h08), acc(1, 0, rd(5'h04)));
        add(0, 0, rd(5'h04), rd(5'h08), rvc(acc(0, 1, rd(5'h08)), 32'h11223344));
        add(0, 0, rd(5'h04), rd(5'h08), rvd(acc(1, 0, rd(5'h04)), 32'h55667788));
        add(0, 0, rd(5'h04), rd(5'h08), rvc(acc(0, 1, rd(5'h08)), 32'h11223344));
        add(0, 0, IDLE, IDLE, rvd(NONE, 32'h55667788));
        add(0, 1, IDLE, wr(5'h10, 32'hDEADBEEF, 2'b11), acc(0, 1, wr(5'h10, 32'hDEADBEEF, 2'b11)));
        add(0, 1, rd(5'h10), IDLE, NONE);
        add(0, 1, rd(5'h10), IDLE, NONE);
        add(0, 1, rd(5'h10), rd(5'h10), acc(0, 1, rd(5'h10)));
        add(0, 0, rd(5'h10), IDLE, rvd(NONE, 32'hDEADBEEF));
        add(0, 0, rd(5'h10), IDLE, acc(1, 0, rd(5'h10)));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'hDEADBEEF));
        add(0, 0, wr(5'h03, 32'h000000AB, 2'b01), IDLE, acc(1, 0, wr(5'h03, 32'h000000AB, 2'b01)));
        add(0, 0, rd(5'h00), IDLE, acc(1, 0, rd(5'h00)));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'hAB000000));
        add(0, 0, wr(5'h00, 32'hFFFFFFFF, 2'b00), IDLE, acc(1, 0, wr(5'h00, 32'hFFFFFFFF, 2'b00)));
        add(0, 0, rd(5'h00), IDLE, acc(1, 0, rd(5'h00)));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'hAB000000));
        add(0, 1, rd(5'h04), IDLE, acc(1, 0, rd(5'h04)));
        add(0, 1, rd(5'h04), IDLE, rvc(acc(1, 0, rd(5'h04)), 32'h11223344));
        add(0, 1, rd(5'h04), IDLE, rvc(acc(1, 0, rd(5'h04)), 32'h11223344));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'h11223344));
        add(0, 0, rd(5'h04), IDLE, acc(1, 0, rd(5'h04)));
        add(1, 0, IDLE, IDLE, NONE);
        add(0, 0, rd(5'h04), rd(5'h08), acc(1, 0, rd(5'h04)));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'h11223344));
        add(0, 1, IDLE, rd(5'h08), acc(0, 1, rd(5'h08)));
        add(1, 1, rd(5'h04), IDLE, NONE);
        add(0, 1, rd(5'h04), IDLE, acc(1, 0, rd(5'h04)));
        add(0, 0, IDLE, IDLE, rvc(NONE, 32'h11223344));

        repeat (2) @(posedge clk);
        foreach (tv[i]) begin
            @(posedge clk); #1;
            drive(tv[i].rst, tv[i].lk, tv[i].c, tv[i].d);
            #4;
            got = {bus.o_cpu_gnt, bus.o_dbg_gnt, bus.o_cpu_rvalid, bus.o_cpu_rdata,
                   bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_mem_wen, bus.o_mem_ren,
                   bus.o_mem_waddr, bus.o_mem_din, bus.o_mem_wsize};
            n_vec++;
            if (got !== tv[i].e || bus.o_mem_raddr !== tv[i].e.addr) begin
                n_bad++;
                $display("FAIL vec%0d: got %h raddr %h, expected %h", i, got, bus.o_mem_raddr, tv[i].e);
            end
        end

        for (int i = 0; i < 32; i++) sb[i] = mem[i];
        exp_c = 1'b0;
        exp_d = 1'b0;
        exp_cd = 32'h0;
        exp_dd = 32'h0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            rc  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   32'($urandom), 2'($urandom_range(0, 3))};
            rdp = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   32'($urandom), 2'($urandom_range(0, 3))};
            drive(1'b0, ($urandom_range(0, 7) == 0), rc, rdp);
            #4;
            n_vec++;
            if ((bus.o_cpu_gnt && bus.o_dbg_gnt) ||
                (bus.o_cpu_gnt && bus.o_mem_waddr !== rc.addr) ||
                (bus.o_dbg_gnt && !bus.o_cpu_gnt && bus.o_mem_waddr !== rdp.addr)) begin
                n_bad++;
                $display("FAIL rnd%0d grant: gnt cpu %b dbg %b addr %h, required one grant with addr cpu %h / dbg %h",
                         k, bus.o_cpu_gnt, bus.o_dbg_gnt, bus.o_mem_waddr, rc.addr, rdp.addr);
            end
            n_vec++;
            if (bus.o_cpu_rvalid !== exp_c || bus.o_cpu_rdata !== (exp_c ? exp_cd : 32'h0) ||
                bus.o_dbg_rvalid !== exp_d || bus.o_dbg_rdata !== (exp_d ? exp_dd : 32'h0)) begin
                n_bad++;
                $display("FAIL rnd%0d response: cpu %b/%h dbg %b/%h, expected cpu %b/%h dbg %b/%h", k,
                         bus.o_cpu_rvalid, bus.o_cpu_rdata, bus.o_dbg_rvalid, bus.o_dbg_rdata,
                         exp_c, exp_cd, exp_d, exp_dd);
            end
            exp_c  = bus.o_cpu_gnt & ~rc.we;
            exp_d  = bus.o_dbg_gnt & ~rdp.we;
            exp_cd = sb_word(rc.addr);
            exp_dd = sb_word(rdp.addr);
            if (bus.o_cpu_gnt && rc.we) sb_write(rc);
            if (bus.o_dbg_gnt && rdp.we) sb_write(rdp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
